fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core. It owns the program counter (PC), selects the next fetch address, and issues one read per cycle to the companion instruction SRAM (`sram_8kb`, 2048 × 32). It also gives an external controller a write path into the SRAM and a one-shot read-back of the fetched instruction word.

## Interface
Clock `clk`, reset `rst`: one clock; reset is synchronous and active-high.

Parameters:
- `ADDR_WIDTH`, default 11: word-address width (2048 words).
- `DATA_WIDTH`, default 32: instruction word width.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset.
- `pc_sel` input 2: next-PC select.
- `alu_addr` input ADDR_WIDTH: jump target from the ALU.
- `imm_addr` input ADDR_WIDTH: branch target from the immediate path.
- `cntlr_rd` input 1: controller read request; a single-cycle pulse is enough.
- `cntlr_rd_data` output DATA_WIDTH: returned instruction word.
- `cntlr_rd_valid` output 1: one-cycle pulse; `cntlr_rd_data` is valid while it is high.
- `cntlr_wr` input 1: controller write strobe.
- `cntlr_waddr` input ADDR_WIDTH: controller write word address.
- `cntlr_wr_data` input DATA_WIDTH: controller write data.
- `mem_rd` output 1: SRAM read enable.
- `mem_rd_addr` output ADDR_WIDTH: SRAM read address.
- `mem_rd_data` input DATA_WIDTH: SRAM read data.
- `mem_wr` output 1: SRAM write enable.
- `mem_wr_addr` output ADDR_WIDTH: SRAM write address.
- `mem_wr_data` output DATA_WIDTH: SRAM write data.

## Operation
- **PC.** PC is a word address.
- **Fetch.** Each non-stalled cycle drives `mem_rd` = 1 and `mem_rd_addr` = PC.
- **Next-PC select.** At each non-stalled edge:
  - `pc_sel` 00: PC ← PC+1, wrapping 2047 → 0.
  - `pc_sel` 01: PC ← `alu_addr`.
  - `pc_sel` 10: PC ← `imm_addr`.
  - `pc_sel` 11: PC holds.
- **Controller write.** Combinational pass-through: `mem_wr` = `cntlr_wr`, `mem_wr_addr` = `cntlr_waddr`, `mem_wr_data` = `cntlr_wr_data`.
- **Stall.** A cycle with `cntlr_wr` = 1 is a stall cycle (see Configuration).
- **Read tracking.** Register `rd_vld_q` ← `mem_rd`. When `rd_vld_q` = 1, `mem_rd_data` holds M[address issued in the previous cycle].
- **Controller read.**
  - A sampled `cntlr_rd` = 1 sets `req_pending`.
  - On the first edge where `req_pending` and `rd_vld_q` are both 1: `cntlr_rd_data` ← `mem_rd_data`, `cntlr_rd_valid` ← 1 for one cycle, and `req_pending` clears.
  - Further `cntlr_rd` pulses while `req_pending` is set merge into that one request.
  - `cntlr_rd` arriving on the same edge as a completion starts a new request.
- **Hold.** `cntlr_rd_data` holds its value between responses.

## Timing
- **Reset.** While `rst` is sampled high:
  - PC = 0, `req_pending` = 0, `rd_vld_q` = 0.
  - `cntlr_rd_valid` = 0, `cntlr_rd_data` = 0.
  - `mem_rd` = 0.
  - Write outputs still follow the controller inputs.
- **First fetch.** The first fetch (address 0) issues in the first cycle after reset deasserts.
- **Reset mid-operation.** Drops any pending request and any valid pulse on the same edge.
- **SRAM contract (`sram_8kb`).**
  - Synchronous write on the rising edge.
  - Synchronous registered read: `rd_data` = M[`rd_addr`] one cycle after `rd_en`, held while `rd_en` = 0.
  - Read and write of the same address in one cycle returns the old data.
- **Fetch latency.** Address issued in cycle N → data on `mem_rd_data` in cycle N+1.
- **Redirect latency.** A `pc_sel` change sampled at edge E sets `mem_rd_addr` = target after E, and the target word appears one cycle later.
- **Controller read latency.** 1–2 cycles from the sampled `cntlr_rd` to `cntlr_rd_valid` with no stall. Each stall cycle extends it by one.
- **Write-then-read.** A write at edge E is visible to a fetch issued after E.

## Configuration
- `FETCH_WR_STALL_EN` defined:
  - A `cntlr_wr` cycle forces `mem_rd` = 0 and holds PC.
  - `rd_vld_q` becomes 0 for the following cycle.
- `FETCH_WR_STALL_EN` undefined:
  - Fetch runs regardless of `cntlr_wr`.
  - A same-address collision returns the old word.

## Test plan
- **Reset.** Hold `rst` 2 cycles, then release → `mem_rd_addr` = 0, 1, 2, … on successive cycles with `pc_sel` = 00, and `cntlr_rd_valid` = 0 throughout reset.
- **Writes then read-back.** Controller writes 0xA5A50001 @5, 0xA5A50002 @6, 0xA5A50003 @7 → `mem_wr` pulses with matching address and data.
  - Then set `pc_sel` = 01 with `alu_addr` = 5 and pulse `cntlr_rd` → `cntlr_rd_valid` pulses once with 0xA5A50001.
- **ALU redirect.** `pc_sel` = 01, `alu_addr` = 6 held 3 cycles → `mem_rd_addr` = 6 from the next edge on, and `mem_rd_data` = 0xA5A50002 one cycle later.
- **Immediate redirect.** `pc_sel` = 10, `imm_addr` = 7 → `mem_rd_addr` = 7, and `mem_rd_data` = 0xA5A50003.
- **Wrap and hold.** Redirect to 2047, then `pc_sel` = 00 → next address 0; `pc_sel` = 11 → address constant for 4 cycles.
- **Stall.** With `FETCH_WR_STALL_EN`, `cntlr_wr` asserted during `req_pending` → PC frozen, `mem_rd` = 0, and `cntlr_rd_valid` delayed by exactly the stall length.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the word-addressed program counter, picks
// the next fetch address and issues one read per cycle to the instruction
// SRAM (sram_8kb). The same block gives an external controller a
// pass-through write path into the SRAM and a one-shot read-back of the
// instruction word being fetched.
//
// Optional build macro:
//   FETCH_WR_STALL_EN - a controller write cycle stalls fetch: mem_rd is
//                       forced low and PC holds. When the macro is left
//                       undefined, fetch runs during writes, and a
//                       same-address collision returns the old word.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc_sel_i        next-PC select: 00 PC+1, 01 ALU, 10 immediate, 11 hold
//   alu_addr_i      jump target from the ALU
//   imm_addr_i      branch target from the immediate path
//   cntlr_rd_i      controller read request (pulse)
//   cntlr_rd_data_o instruction word returned to the controller
//   cntlr_rd_valid_o one-cycle strobe qualifying cntlr_rd_data_o
//   cntlr_wr_i      controller write strobe
//   cntlr_waddr_i   controller write word address
//   cntlr_wr_data_i controller write data
//   mem_rd_o        SRAM read enable
//   mem_rd_addr_o   SRAM read address (the PC)
//   mem_rd_data_i   SRAM registered read data
//   mem_wr_o        SRAM write enable
//   mem_wr_addr_o   SRAM write address
//   mem_wr_data_o   SRAM write data
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pc_sel_i,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [ADDR_WIDTH-1:0] imm_addr_i,
    input  logic                  cntlr_rd_i,
    output logic [DATA_WIDTH-1:0] cntlr_rd_data_o,
    output logic                  cntlr_rd_valid_o,
    input  logic                  cntlr_wr_i,
    input  logic [ADDR_WIDTH-1:0] cntlr_waddr_i,
    input  logic [DATA_WIDTH-1:0] cntlr_wr_data_i,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  rd_vld_q;
    logic                  req_pending_q, req_pending_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  stall;
    logic                  complete;

`ifdef FETCH_WR_STALL_EN
    assign stall = cntlr_wr_i;
`else
    assign stall = 1'b0;
`endif

    // Controller writes go straight to the SRAM, also during reset.
    assign mem_wr_o      = cntlr_wr_i;
    assign mem_wr_addr_o = cntlr_waddr_i;
    assign mem_wr_data_o = cntlr_wr_data_i;

    // Fetch is gated by reset directly so the first read of address 0
    // issues in the very first cycle with rst low.
    assign mem_rd_o      = ~rst & ~stall;
    assign mem_rd_addr_o = pc_q;

    assign cntlr_rd_data_o  = rd_data_q;
    assign cntlr_rd_valid_o = rd_valid_q;

    // Next PC; the increment wraps naturally at the top of the word space.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            unique case (pc_sel_i)
                2'b00:   pc_d = pc_q + ADDR_WIDTH'(1);
                2'b01:   pc_d = alu_addr_i;
                2'b10:   pc_d = imm_addr_i;
                default: pc_d = pc_q;
            endcase
        end
    end

    // A pending request completes on the first edge where SRAM data is
    // valid. A new pulse on that same edge re-arms the request; pulses
    // while already pending simply merge into it.
    always_comb begin
        complete      = req_pending_q & rd_vld_q;
        req_pending_d = (req_pending_q & ~complete) | cntlr_rd_i;
        rd_valid_d    = complete;
        rd_data_d     = rd_data_q;
        if (complete) begin
            rd_data_d = mem_rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            rd_vld_q      <= 1'b0;
            req_pending_q <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rd_vld_q      <= mem_rd_o;
            req_pending_q <= req_pending_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    pc_sel = 2'b00;
    logic [AW-1:0] alu_addr = '0;
    logic [AW-1:0] imm_addr = '0;
    logic          cntlr_rd = 1'b0;
    logic [DW-1:0] cntlr_rd_data;
    logic          cntlr_rd_valid;
    logic          cntlr_wr = 1'b0;
    logic [AW-1:0] cntlr_waddr = '0;
    logic [DW-1:0] cntlr_wr_data = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_wr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_sel_i         (pc_sel),
        .alu_addr_i       (alu_addr),
        .imm_addr_i       (imm_addr),
        .cntlr_rd_i       (cntlr_rd),
        .cntlr_rd_data_o  (cntlr_rd_data),
        .cntlr_rd_valid_o (cntlr_rd_valid),
        .cntlr_wr_i       (cntlr_wr),
        .cntlr_waddr_i    (cntlr_waddr),
        .cntlr_wr_data_i  (cntlr_wr_data),
        .mem_rd_o         (mem_rd),
        .mem_rd_addr_o    (mem_rd_addr),
        .mem_rd_data_i    (mem_rd_data),
        .mem_wr_o         (mem_wr),
        .mem_wr_addr_o    (mem_wr_addr),
        .mem_wr_data_o    (mem_wr_data)
    );

    // sram_8kb behaviour: synchronous write, registered read, old data on collision.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    end

    always @(posedge clk) begin
        if (mem_wr) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_sel = 2'b00;
        cntlr_wr = 1'b1;
        cntlr_waddr = 11'd100;
        cntlr_wr_data = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b1 || mem_wr_addr !== 11'd100 || mem_wr_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL reset_wr_pass: got wr=%b addr=%0d data=%h expected wr=1 addr=100 data=deadbeef",
                     mem_wr, mem_wr_addr, mem_wr_data);
        end
        n_checks++;
        if (mem_rd !== 1'b0 || cntlr_rd_valid !== 1'b0 || cntlr_rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mem_rd=%b valid=%b data=%h expected 0 0 0",
                     mem_rd, cntlr_rd_valid, cntlr_rd_data);
        end
        cntlr_wr = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b0 || cntlr_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got mem_rd=%b valid=%b expected 0 0", mem_rd, cntlr_rd_valid);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_rd !== 1'b1 || mem_rd_addr !== 11'(i)) begin
                n_fail++;
                $display("FAIL first_fetch%0d: got rd=%b addr=%0d expected rd=1 addr=%0d",
                         i, mem_rd, mem_rd_addr, i);
            end
            if (i > 0) begin
                n_checks++;
                if (mem_rd_data !== 32'hC0DE_0000 + 32'(i - 1)) begin
                    n_fail++;
                    $display("FAIL first_data%0d: got %h expected %h",
                             i, mem_rd_data, 32'hC0DE_0000 + 32'(i - 1));
                end
            end
            n_checks++;
            if (cntlr_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid%0d: got %b expected 0", i, cntlr_rd_valid);
            end
            tick();
        end
    endtask

    task automatic test_writes();
        for (int k = 0; k < 3; k++) begin
            cntlr_wr = 1'b1;
            cntlr_waddr = 11'(5 + k);
            cntlr_wr_data = 32'hA5A5_0001 + 32'(k);
            @(negedge clk);
            n_checks++;
            if (mem_wr !== 1'b1 || mem_wr_addr !== 11'(5 + k) || mem_wr_data !== 32'hA5A5_0001 + 32'(k)) begin
                n_fail++;
                $display("FAIL write%0d: got wr=%b addr=%0d data=%h expected wr=1 addr=%0d data=%h",
                         k, mem_wr, mem_wr_addr, mem_wr_data, 5 + k, 32'hA5A5_0001 + 32'(k));
            end
            tick();
        end
        cntlr_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL write_idle: got %b expected 0", mem_wr);
        end
        // Read-back of word 5 through the controller port.
        pc_sel = 2'b01;
        alu_addr = 11'd5;
        tick();
        cntlr_rd = 1'b1;
        tick();
        cntlr_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL readback_early: got valid=%b expected 0", cntlr_rd_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL readback: got valid=%b data=%h expected valid=1 data=a5a50001",
                     cntlr_rd_valid, cntlr_rd_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b0 || cntlr_rd_data !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL readback_hold: got valid=%b data=%h expected valid=0 data=a5a50001",
                     cntlr_rd_valid, cntlr_rd_data);
        end
    endtask

    task automatic test_alu_redirect();
        pc_sel = 2'b01;
        alu_addr = 11'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (mem_rd_addr !== 11'd6) begin
                n_fail++;
                $display("FAIL alu_addr%0d: got %0d expected 6", i, mem_rd_addr);
            end
            if (i > 0) begin
                n_checks++;
                if (mem_rd_data !== 32'hA5A5_0002) begin
                    n_fail++;
                    $display("FAIL alu_data%0d: got %h expected a5a50002", i, mem_rd_data);
                end
            end
        end
    endtask

    task automatic test_imm_redirect();
        pc_sel = 2'b10;
        imm_addr = 11'd7;
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_rd_addr !== 11'd7) begin
            n_fail++;
            $display("FAIL imm_addr: got %0d expected 7", mem_rd_addr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_rd_data !== 32'hA5A5_0003) begin
            n_fail++;
            $display("FAIL imm_data: got %h expected a5a50003", mem_rd_data);
        end
    endtask

    task automatic test_wrap_hold();
        pc_sel = 2'b01;
        alu_addr = 11'd2047;
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_rd_addr !== 11'd2047) begin
            n_fail++;
            $display("FAIL wrap_top: got %0d expected 2047", mem_rd_addr);
        end
        pc_sel = 2'b00;
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_rd_addr !== 11'd0 || mem_rd_data !== 32'hC0DE_07FF) begin
            n_fail++;
            $display("FAIL wrap_zero: got addr=%0d data=%h expected addr=0 data=c0de07ff",
                     mem_rd_addr, mem_rd_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_rd_addr !== 11'd1) begin
            n_fail++;
            $display("FAIL wrap_one: got %0d expected 1", mem_rd_addr);
        end
        pc_sel = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (mem_rd_addr !== 11'd1 || mem_rd_data !== 32'hC0DE_0001) begin
                n_fail++;
                $display("FAIL hold%0d: got addr=%0d data=%h expected addr=1 data=c0de0001",
                         i, mem_rd_addr, mem_rd_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Second pulse lands on the completion edge of the first: two responses.
        cntlr_rd = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pre: got %b expected 0", cntlr_rd_valid);
        end
        tick();
        cntlr_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hC0DE_0001) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%b data=%h expected valid=1 data=c0de0001",
                     cntlr_rd_valid, cntlr_rd_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hC0DE_0001) begin
            n_fail++;
            $display("FAIL b2b_second: got valid=%b data=%h expected valid=1 data=c0de0001",
                     cntlr_rd_valid, cntlr_rd_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got %b expected 0", cntlr_rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        pc_sel = 2'b00;
        cntlr_rd = 1'b1;
        tick();
        cntlr_rd = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b0 || cntlr_rd_data !== 32'h0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: got valid=%b data=%h rd=%b expected 0 0 0",
                     cntlr_rd_valid, cntlr_rd_data, mem_rd);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (cntlr_rd_valid !== 1'b0 || mem_rd_addr !== 11'(i)) begin
                n_fail++;
                $display("FAIL midrst_after%0d: got valid=%b addr=%0d expected valid=0 addr=%0d",
                         i, cntlr_rd_valid, mem_rd_addr, i);
            end
            tick();
        end
    endtask

`ifdef FETCH_WR_STALL_EN
    task automatic test_stall();
        pc_sel = 2'b01;
        alu_addr = 11'd6;
        tick();
        // Two-cycle write burst overlapping the read request.
        pc_sel = 2'b00;
        cntlr_rd = 1'b1;
        cntlr_wr = 1'b1;
        cntlr_waddr = 11'd20;
        cntlr_wr_data = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_rd !== 1'b0 || mem_rd_addr !== 11'd6 || cntlr_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: got rd=%b addr=%0d valid=%b expected rd=0 addr=6 valid=0",
                         i, mem_rd, mem_rd_addr, cntlr_rd_valid);
            end
            tick();
            cntlr_rd = 1'b0;
        end
        cntlr_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b1 || mem_rd_addr !== 11'd6 || cntlr_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_resume: got rd=%b addr=%0d valid=%b expected rd=1 addr=6 valid=0",
                     mem_rd, mem_rd_addr, cntlr_rd_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_rd_addr !== 11'd7 || cntlr_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_wait: got addr=%0d valid=%b expected addr=7 valid=0",
                     mem_rd_addr, cntlr_rd_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hA5A5_0002) begin
            n_fail++;
            $display("FAIL stall_resp: got valid=%b data=%h expected valid=1 data=a5a50002",
                     cntlr_rd_valid, cntlr_rd_data);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_writes();
        test_alu_redirect();
        test_imm_redirect();
        test_wrap_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef FETCH_WR_STALL_EN
        test_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
